// File: rtl/mem_bus_arbiter.sv
// Arbiter for the single synchronous RAM port shared by the CPU (default owner,
// stalled through its clock enable) and one DMA/loader master.
module mem_bus_arbiter #(
    parameter int MAX_BURST = 16,
    parameter int CPU_SLOT  = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_cpu_addr,
    input  logic [15:0] i_cpu_wdata,
    input  logic        i_cpu_we,
    input  logic        i_cpu_halted,
    output logic        o_cpu_ce,
    output logic [15:0] o_cpu_rdata,
    input  logic        i_dma_req,
    input  logic [15:0] i_dma_addr,
    input  logic [15:0] i_dma_wdata,
    input  logic        i_dma_we,
    output logic        o_dma_gnt,
    output logic [15:0] o_dma_rdata,
    output logic        o_dma_rvalid,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_wdata,
    output logic        o_mem_we,
    input  logic [15:0] i_mem_rdata
);

    localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam int GW = (CPU_SLOT > 0) ? $clog2(CPU_SLOT + 1) : 1;
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
    localparam logic [GW-1:0] SLOT_LEN  = GW'(CPU_SLOT);

    typedef enum logic [1:0] {
        S_CPU,
        S_DMA,
        S_REFILL
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [BW-1:0] burst_cnt;
    logic [BW-1:0] burst_nxt;
    logic [BW-1:0] burst_inc;
    logic [GW-1:0] guard;
    logic [GW-1:0] guard_nxt;
    logic [GW-1:0] guard_dec;
    logic          rvalid;
    logic          beat;

    assign beat      = (state == S_DMA) && i_dma_req;
    assign burst_inc = (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + 1'b1;
    assign guard_dec = (guard == '0) ? guard : guard - 1'b1;

    // The guard is tested after this cycle's decrement, so a request held
    // through the slot is granted on the CPU_SLOT-th CPU cycle.
    always_comb begin
        state_nxt   = state;
        burst_nxt   = burst_cnt;
        guard_nxt   = guard;
        o_cpu_ce    = 1'b1;
        o_dma_gnt   = 1'b0;
        o_mem_addr  = i_cpu_addr;
        o_mem_wdata = i_cpu_wdata;
        o_mem_we    = 1'b0;
        unique case (state)
            S_CPU: begin
                o_mem_we  = i_cpu_we;
                guard_nxt = guard_dec;
                if (i_dma_req && (i_cpu_halted || guard_dec == '0)) begin
                    state_nxt = S_DMA;
                    burst_nxt = '0;
                end
            end
            S_DMA: begin
                o_cpu_ce    = 1'b0;
                o_dma_gnt   = 1'b1;
                o_mem_addr  = i_dma_addr;
                o_mem_wdata = i_dma_wdata;
                o_mem_we    = i_dma_we & i_dma_req;
                if (i_dma_req) begin
                    burst_nxt = burst_inc;
                end
                if (!i_dma_req || (burst_inc == BURST_MAX && !i_cpu_halted)) begin
                    state_nxt = S_REFILL;
                end
            end
            S_REFILL: begin
                o_cpu_ce  = 1'b0;
                state_nxt = S_CPU;
                guard_nxt = SLOT_LEN;
            end
            default: begin
                state_nxt = S_CPU;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_CPU;
            burst_cnt <= '0;
            guard     <= '0;
            rvalid    <= 1'b0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_nxt;
            guard     <= guard_nxt;
            rvalid    <= beat && !i_dma_we;
        end
    end

    // RAM data arrives one cycle after the address, aligned with rvalid.
    assign o_dma_rvalid = rvalid;
    assign o_dma_rdata  = rvalid ? i_mem_rdata : '0;
    assign o_cpu_rdata  = i_mem_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: hand vectors, multi-cycle corner sequences and
// a randomized run against a cycle-level reference model with its own RAM copy.
module tb_mem_bus_arbiter;

    localparam int MAX_BURST = 16;
    localparam int CPU_SLOT  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_we;
    logic        cpu_halted;
    logic        cpu_ce;
    logic [15:0] cpu_rdata;
    logic        dma_req;
    logic [15:0] dma_addr;
    logic [15:0] dma_wdata;
    logic        dma_we;
    logic        dma_gnt;
    logic [15:0] dma_rdata;
    logic        dma_rvalid;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .MAX_BURST(MAX_BURST),
        .CPU_SLOT (CPU_SLOT)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cpu_addr  (cpu_addr),
        .i_cpu_wdata (cpu_wdata),
        .i_cpu_we    (cpu_we),
        .i_cpu_halted(cpu_halted),
        .o_cpu_ce    (cpu_ce),
        .o_cpu_rdata (cpu_rdata),
        .i_dma_req   (dma_req),
        .i_dma_addr  (dma_addr),
        .i_dma_wdata (dma_wdata),
        .i_dma_we    (dma_we),
        .o_dma_gnt   (dma_gnt),
        .o_dma_rdata (dma_rdata),
        .o_dma_rvalid(dma_rvalid),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_mem_we    (mem_we),
        .i_mem_rdata (mem_rdata)
    );

    function automatic logic [15:0] seed_val(logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    // Synchronous RAM, read-first, 1-cycle latency.
    logic [15:0] ram     [0:65535];
    bit          ram_set [0:65535];
    logic [15:0] ram_q = 16'h0000;
    int          wr201 = 0;

    always @(posedge clk) begin
        ram_q <= ram_set[mem_addr] ? ram[mem_addr] : seed_val(mem_addr);
        if (mem_we) begin
            ram[mem_addr]     <= mem_wdata;
            ram_set[mem_addr] <= 1'b1;
        end
        if (mem_we && mem_addr == 16'h0201) wr201 <= wr201 + 1;
    end
    assign mem_rdata = ram_q;

    int checks   = 0;
    int failures = 0;

    task automatic chk1(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%b expected=%b", name, $time, act, exp);
        end
    endtask

    task automatic chk16(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
        end
    endtask

    // Reference model: who owns the bus, beats in this grant, CPU cycles
    // since the last refill, and an independent copy of RAM contents.
    logic [15:0] ref_mem [int];
    bit          m_dma    = 1'b0;
    bit          m_refill = 1'b0;
    bit          m_rv     = 1'b0;
    int          m_beats  = 0;
    int          m_cpu_n  = CPU_SLOT;
    logic [15:0] m_rd     = 16'h0000;
    logic        e_ce;
    logic        e_gnt;
    logic        e_we;
    logic [15:0] e_addr;
    logic [15:0] e_wdata;

    task automatic model_outputs();
        e_gnt   = m_dma;
        e_ce    = !m_dma && !m_refill;
        e_addr  = m_dma ? dma_addr : cpu_addr;
        e_wdata = m_dma ? dma_wdata : cpu_wdata;
        if (m_dma) e_we = dma_we && dma_req;
        else if (m_refill) e_we = 1'b0;
        else e_we = cpu_we;
    endtask

    task automatic model_step();
        int k;
        model_outputs();
        k    = int'(e_addr);
        m_rd = ref_mem.exists(k) ? ref_mem[k] : seed_val(e_addr);
        if (e_we) ref_mem[k] = e_wdata;
        m_rv = 1'b0;
        if (rst) begin
            m_dma    = 1'b0;
            m_refill = 1'b0;
            m_beats  = 0;
            m_cpu_n  = CPU_SLOT;
        end else if (m_refill) begin
            m_refill = 1'b0;
            m_cpu_n  = 0;
        end else if (m_dma) begin
            if (dma_req) begin
                m_beats++;
                m_rv = !dma_we;
            end
            if (!dma_req || (m_beats >= MAX_BURST && !cpu_halted)) begin
                m_dma    = 1'b0;
                m_refill = 1'b1;
            end
        end else begin
            if (m_cpu_n < 1000) m_cpu_n++;
            if (dma_req && (cpu_halted || m_cpu_n >= CPU_SLOT)) begin
                m_dma   = 1'b1;
                m_beats = 0;
            end
        end
    endtask

    task automatic model_check();
        model_outputs();
        chk1("cpu_ce", cpu_ce, e_ce);
        chk1("dma_gnt", dma_gnt, e_gnt);
        chk16("mem_addr", mem_addr, e_addr);
        chk16("mem_wdata", mem_wdata, e_wdata);
        chk1("mem_we", mem_we, e_we);
        chk1("dma_rvalid", dma_rvalid, m_rv);
        if (m_rv) chk16("dma_rdata", dma_rdata, m_rd);
        chk16("cpu_rdata", cpu_rdata, m_rd);
    endtask

    task automatic to_neg();
        @(negedge clk);
        model_check();
    endtask

    task automatic to_pos();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(bit r, logic [15:0] ca, logic [15:0] cw, bit cwe, bit h,
                         bit rq, logic [15:0] da, logic [15:0] dw, bit dwe);
        rst        = r;
        cpu_addr   = ca;
        cpu_wdata  = cw;
        cpu_we     = cwe;
        cpu_halted = h;
        dma_req    = rq;
        dma_addr   = da;
        dma_wdata  = dw;
        dma_we     = dwe;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 16'h0060 + 16'(i), 16'h0, 0, 0, 0, 16'h0, 16'h0, 0);
            to_neg();
            to_pos();
        end
    endtask

    typedef struct {
        logic [15:0] ca;
        logic        cwe;
        logic        rq;
        logic [15:0] da;
        logic        x_ce;
        logic        x_gnt;
        logic [15:0] x_addr;
        logic        x_we;
        logic        x_rv;
        logic [15:0] x_rdata;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int c0;
        bit rq;
        bit h;

        tbl[0] = '{16'h0010, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0, 16'h0000};
        tbl[1] = '{16'h0011, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0011, 1'b1, 1'b0, 16'h0000};
        tbl[2] = '{16'h0012, 1'b0, 1'b1, 16'h0100, 1'b1, 1'b0, 16'h0012, 1'b0, 1'b0, 16'h0000};
        tbl[3] = '{16'h0013, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 16'h0000};
        tbl[4] = '{16'h0013, 1'b0, 1'b1, 16'h0101, 1'b0, 1'b1, 16'h0101, 1'b0, 1'b1, 16'h5B5A};
        tbl[5] = '{16'h0013, 1'b0, 1'b1, 16'h0102, 1'b0, 1'b1, 16'h0102, 1'b0, 1'b1, 16'h5B5B};
        tbl[6] = '{16'h0013, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 16'h5B58};
        tbl[7] = '{16'h0013, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0013, 1'b0, 1'b0, 16'h0000};
        tbl[8] = '{16'h0013, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0013, 1'b0, 1'b0, 16'h0000};

        drive(1, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 0);
        to_pos();
        to_neg();
        chk1("rst_ce", cpu_ce, 1'b1);
        chk1("rst_gnt", dma_gnt, 1'b0);
        chk1("rst_rvalid", dma_rvalid, 1'b0);
        chk16("rst_rdata", dma_rdata, 16'h0000);
        to_pos();

        for (int i = 0; i < 9; i++) begin
            drive(0, tbl[i].ca, 16'h1111, tbl[i].cwe, 0, tbl[i].rq, tbl[i].da, 16'h0, 0);
            to_neg();
            chk1($sformatf("tbl%0d_ce", i), cpu_ce, tbl[i].x_ce);
            chk1($sformatf("tbl%0d_gnt", i), dma_gnt, tbl[i].x_gnt);
            chk16($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].x_addr);
            chk1($sformatf("tbl%0d_we", i), mem_we, tbl[i].x_we);
            chk1($sformatf("tbl%0d_rv", i), dma_rvalid, tbl[i].x_rv);
            if (tbl[i].x_rv) chk16($sformatf("tbl%0d_rdata", i), dma_rdata, tbl[i].x_rdata);
            to_pos();
        end

        // DMA write while the stalled CPU holds a pending write.
        idle(6);
        c0 = wr201;
        drive(0, 16'h0050, 16'h0, 0, 0, 1, 16'h0200, 16'hBEEF, 1);
        to_neg();
        to_pos();
        drive(0, 16'h0201, 16'hC0DE, 1, 0, 1, 16'h0200, 16'hBEEF, 1);
        to_neg();
        chk1("wr_dma_we", mem_we, 1'b1);
        chk16("wr_dma_addr", mem_addr, 16'h0200);
        to_pos();
        drive(0, 16'h0201, 16'hC0DE, 1, 0, 0, 16'h0000, 16'h0, 0);
        to_neg();
        chk1("wr_idle_we", mem_we, 1'b0);
        to_pos();
        to_neg();
        chk1("wr_refill_we", mem_we, 1'b0);
        chk16("wr_refill_addr", mem_addr, 16'h0201);
        to_pos();
        to_neg();
        chk1("wr_cpu_we", mem_we, 1'b1);
        chk16("wr_cpu_addr", mem_addr, 16'h0201);
        to_pos();
        drive(0, 16'h0202, 16'h0, 0, 0, 0, 16'h0, 16'h0, 0);
        to_neg();
        to_pos();
        chk16("ram_0200", ram[16'h0200], 16'hBEEF);
        chk16("ram_0201", ram[16'h0201], 16'hC0DE);
        chk16("cpu_wr_once", 16'(wr201 - c0), 16'd1);

        // Request held: 16 beats, 1 refill, 4 CPU cycles, repeated.
        idle(6);
        for (int i = 0; i < 40; i++) begin
            drive(0, 16'h0070, 16'h0, 0, 0, 1, 16'h0400 + 16'(i), 16'h0, 0);
            to_neg();
            chk1($sformatf("hold_gnt%0d", i), dma_gnt, i >= 1 && ((i - 1) % 21) < 16);
            to_pos();
        end

        // Halted CPU: one uninterrupted grant of 40 beats.
        idle(6);
        for (int i = 0; i < 41; i++) begin
            drive(0, 16'h0071, 16'h0, 0, 1, 1, 16'h0500 + 16'(i), 16'h0, 0);
            to_neg();
            chk1($sformatf("halt_gnt%0d", i), dma_gnt, i >= 1);
            to_pos();
        end

        // Reset on beat 5 of a read burst.
        idle(6);
        for (int i = 0; i < 5; i++) begin
            drive(0, 16'h0072, 16'h0, 0, 0, 1, 16'h0600 + 16'(i), 16'h0, 0);
            to_neg();
            to_pos();
        end
        drive(1, 16'h0072, 16'h0, 0, 0, 1, 16'h0605, 16'h0, 0);
        to_neg();
        chk1("beat5_gnt", dma_gnt, 1'b1);
        to_pos();
        drive(0, 16'h0072, 16'h0, 0, 0, 0, 16'h0, 16'h0, 0);
        to_neg();
        chk1("post_rst_ce", cpu_ce, 1'b1);
        chk1("post_rst_gnt", dma_gnt, 1'b0);
        chk1("post_rst_rvalid", dma_rvalid, 1'b0);
        to_pos();

        // Randomized traffic with bursty requests and a slowly changing halt.
        rq = 1'b0;
        h  = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) rq = !rq;
            if ($urandom_range(0, 39) == 0) h = !h;
            drive($urandom_range(0, 149) == 0,
                  16'h0300 + 16'($urandom_range(0, 31)), 16'($urandom),
                  $urandom_range(0, 3) == 0, h, rq,
                  16'h0300 + 16'($urandom_range(0, 31)), 16'($urandom),
                  $urandom_range(0, 1) == 1);
            to_neg();
            to_pos();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
